// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for the PC sequencer: next-PC controls and targets in,
// current PC, increment and return-stack status out.
interface pc_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_target;
  logic             branch;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_result;
  logic [WIDTH-1:0] pc_plus;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, redirect, redirect_target, branch, branch_target,
           jump, jump_target, call, ret,
    input  pc_result, pc_plus, ras_count, ras_empty, ras_full
  );

  modport slave (
    input  stall, redirect, redirect_target, branch, branch_target,
           jump, jump_target, call, ret,
    output pc_result, pc_plus, ras_count, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection with a circular
// return-address stack that predicts Return targets.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  pc_sequencer_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus;
  logic [PW-1:0]    top_inc;
  logic             ras_empty;
  logic             ras_full;

  assign pc_plus   = pc_q + WIDTH'(INC);
  assign top_inc   = top_q + PW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ras_d = ras_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_target;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.branch) begin
      pc_d = bus.branch_target;
    end else if (bus.jump) begin
      if (bus.ret && !ras_empty) begin
        pc_d = ras_q[top_q];
        // Call+Return swaps the top entry in place; depth is unchanged.
        if (bus.call) begin
          ras_d[top_q] = pc_plus;
        end else begin
          top_d = top_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        pc_d = bus.jump_target;
        // A full stack wraps and overwrites its oldest entry.
        if (bus.call) begin
          ras_d[top_inc] = pc_plus;
          top_d          = top_inc;
          if (!ras_full) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    end else begin
      pc_d = pc_plus;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ras_q[gi] <= '0;
      end else begin
        ras_q[gi] <= ras_d[gi];
      end
    end
  end

  assign bus.pc_result = pc_q;
  assign bus.pc_plus   = pc_plus;
  assign bus.ras_count = cnt_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit and an 8-bit instance, expected
// PC/RAS state queued per step and compared one cycle later.
module tb_pc_sequencer;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   on8;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    int          cnt;
  } exp_t;

  exp_t sb[$];

  pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) b32 ();
  pc_sequencer_if #(.WIDTH(8),  .RAS_DEPTH(4)) b8 ();

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut32 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b32)
  );

  pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h0), .INC(4), .RAS_DEPTH(4)) dut8 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    b32.stall = 0; b32.redirect = 0; b32.redirect_target = '0;
    b32.branch = 0; b32.branch_target = '0;
    b32.jump = 0; b32.jump_target = '0; b32.call = 0; b32.ret = 0;
    b8.stall = 0; b8.redirect = 0; b8.redirect_target = '0;
    b8.branch = 0; b8.branch_target = '0;
    b8.jump = 0; b8.jump_target = '0; b8.call = 0; b8.ret = 0;
  endtask

  // Queue the expectation, clock once, then compare the selected instance.
  task automatic step(input string tag, input logic [31:0] exp_pc, input int exp_cnt);
    exp_t e;
    logic [31:0] pc, plus, cnt, emp, ful, eplus;
    sb.push_back('{tag: tag, pc: exp_pc, cnt: exp_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (on8) begin
      pc = {24'h0, b8.pc_result}; plus = {24'h0, b8.pc_plus};
      cnt = {29'h0, b8.ras_count}; emp = {31'h0, b8.ras_empty}; ful = {31'h0, b8.ras_full};
      eplus = (e.pc + 32'd4) & 32'hFF;
    end else begin
      pc = b32.pc_result; plus = b32.pc_plus;
      cnt = {29'h0, b32.ras_count}; emp = {31'h0, b32.ras_empty}; ful = {31'h0, b32.ras_full};
      eplus = e.pc + 32'd4;
    end
    chk({e.tag, ".pc"}, pc, e.pc);
    chk({e.tag, ".plus"}, plus, eplus);
    chk({e.tag, ".count"}, cnt, 32'(e.cnt));
    chk({e.tag, ".empty"}, emp, (e.cnt == 0) ? 32'd1 : 32'd0);
    chk({e.tag, ".full"}, ful, (e.cnt == 4) ? 32'd1 : 32'd0);
    $display("step %-12s pc=%h count=%0d", e.tag, pc, cnt);
    clr();
  endtask

  task automatic call32(input logic [31:0] tgt);
    b32.jump = 1; b32.call = 1; b32.jump_target = tgt;
  endtask

  task automatic ret32(input logic [31:0] tgt);
    b32.jump = 1; b32.ret = 1; b32.jump_target = tgt;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    on8 = 0;
    rst_n = 0;
    clr();
    #3;
    chk("rst.pc", b32.pc_result, 32'h0);
    chk("rst.count", {29'h0, b32.ras_count}, 32'h0);
    chk("rst.empty", {31'h0, b32.ras_empty}, 32'h1);
    chk("rst.pc8", {24'h0, b8.pc_result}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 1; i <= 16; i++) step("free", 32'(4 * i), 0);

    // Asynchronous reset mid-cycle, seen before the next edge.
    #2;
    rst_n = 0;
    #1;
    chk("arst.pc", b32.pc_result, 32'h0);
    chk("arst.empty", {31'h0, b32.ras_empty}, 32'h1);
    @(posedge clk);
    #1;
    chk("arst.hold", b32.pc_result, 32'h0);
    rst_n = 1;
    step("rel1", 32'h4, 0);
    step("rel2", 32'h8, 0);
    step("rel3", 32'hC, 0);
    step("to10", 32'h10, 0);

    for (int i = 0; i < 3; i++) begin
      b32.stall = 1;
      step("stall", 32'h10, 0);
    end
    b32.stall = 1; b32.redirect = 1; b32.redirect_target = 32'h80;
    step("stall_redir", 32'h80, 0);

    b32.branch = 1; b32.branch_target = 32'h200; call32(32'h300);
    step("br_vs_jmp", 32'h200, 0);
    b32.redirect = 1; b32.redirect_target = 32'h1000;
    b32.branch = 1; b32.branch_target = 32'h200;
    step("redir_vs_br", 32'h1000, 0);
    b32.redirect = 1; b32.redirect_target = 32'h100; call32(32'h300);
    step("redir_call", 32'h100, 0);
    b32.stall = 1; call32(32'h300);
    step("stall_call", 32'h100, 0);

    call32(32'h400);
    step("call", 32'h400, 1);
    ret32(32'hDEAD);
    step("ret", 32'h104, 0);

    b32.redirect = 1; b32.redirect_target = 32'h0;
    step("to0", 32'h0, 0);
    for (int i = 1; i <= 5; i++) begin
      call32(32'(16 * i));
      step("call5", 32'(16 * i), (i > 4) ? 4 : i);
    end
    for (int i = 4; i >= 1; i--) begin
      ret32(32'h999);
      step("ret4", 32'(16 * i + 4), i - 1);
    end
    ret32(32'h900);
    step("ret_empty", 32'h900, 0);

    // Call+Return on an empty stack degrades to a plain push.
    call32(32'h500); b32.ret = 1;
    step("cr_empty", 32'h500, 1);
    ret32(32'h0);
    step("cr_pop", 32'h904, 0);

    on8 = 1;
    b8.redirect = 1; b8.redirect_target = 8'hFC;
    step("w8_fc", 32'hFC, 0);
    step("w8_wrap", 32'h00, 0);
    b8.redirect = 1; b8.redirect_target = 8'h50;
    step("w8_50", 32'h50, 0);
    b8.jump = 1; b8.call = 1; b8.jump_target = 8'h20;
    step("w8_call", 32'h20, 1);
    b8.jump = 1; b8.call = 1; b8.ret = 1; b8.jump_target = 8'h77;
    step("w8_swap", 32'h54, 1);
    b8.jump = 1; b8.ret = 1; b8.jump_target = 8'h77;
    step("w8_ret", 32'h24, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
